// File: rtl/lcd_char_driver_if.sv
// Display-list and LCD pin bundle for lcd_char_driver.
//   char_in    : character byte returned by the display list (one cycle after index)
//   index      : character index requested from the display list
//   lcd_rs     : 0 = command, 1 = data
//   lcd_rw     : write-only, tied low
//   lcd_e      : LCD enable strobe
//   lcd_data   : LCD 8-bit data bus
//   init_done  : power-up init sequence finished
//   frame_done : one-cycle pulse after the last character's post-transfer wait
// master = the driver, slave = display list / LCD / observer side.
interface lcd_char_driver_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  char_in,
        output index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
    );

    modport slave (
        output char_in,
        input  index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
    );
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver, 8-bit write-only mode.
// Runs the power-up init command list, then refreshes both lines forever:
// 0x80, chars 0..15, 0xC0, chars 16..31, idle gap, repeat.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset (full restart from power-up wait)
//   bus : lcd_char_driver_if.master (display-list index/char_in, LCD pins,
//         init_done, frame_done)
// Every byte goes through SETUP (E low) -> EHIGH -> HOLD (E low) -> WAIT.
// All timing phases share one 24-bit down-counter; every *_CYC must be >= 1
// and SETUP_CYC must be >= 2.
module lcd_char_driver #(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_HIGH_CYC   = 25,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000,
    parameter int unsigned REFRESH_CYC  = 500000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_char_driver_if.master  bus
);

    localparam logic [23:0] L_PWRUP   = 24'(PWRUP_CYC);
    localparam logic [23:0] L_SETUP   = 24'(SETUP_CYC);
    localparam logic [23:0] L_EHIGH   = 24'(E_HIGH_CYC);
    localparam logic [23:0] L_HOLD    = 24'(HOLD_CYC);
    localparam logic [23:0] L_CMD     = 24'(CMD_WAIT_CYC);
    localparam logic [23:0] L_CLR     = 24'(CLR_WAIT_CYC);
    localparam logic [23:0] L_REFRESH = 24'(REFRESH_CYC);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_ADDR1, ST_CHAR, ST_ADDR2, ST_REFRESH
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_EHIGH, PH_HOLD, PH_WAIT
    } phase_t;

    state_t      state, state_n;
    state_t      nxt, nxt_n;       // state to enter once the current WAIT expires
    phase_t      phase, phase_n;
    logic [23:0] cnt, cnt_n;
    logic [2:0]  step, step_n;     // position in the init command list
    logic [4:0]  index, index_n;
    logic        rs, rs_n;
    logic        e, e_n;
    logic [7:0]  data, data_n;
    logic        init_done, init_done_n;
    logic        frame_done, frame_done_n;
    logic [7:0]  byte_sel;
    logic        last;

    function automatic logic [7:0] init_cmd(input logic [2:0] s);
        case (s)
            3'd0, 3'd1: init_cmd = 8'h38;
            3'd2:       init_cmd = 8'h0C;
            3'd3:       init_cmd = 8'h06;
            default:    init_cmd = 8'h01;
        endcase
    endfunction

    // Phases load their full length on entry and end in the cycle cnt == 1.
    assign last = (cnt == 24'd1);

    always_comb begin
        byte_sel = init_cmd(step);
        case (state)
            ST_ADDR1: byte_sel = 8'h80;
            ST_ADDR2: byte_sel = 8'hC0;
            ST_CHAR:  byte_sel = bus.char_in;
            default:  ;
        endcase
    end

    always_comb begin
        state_n      = state;
        nxt_n        = nxt;
        phase_n      = phase;
        cnt_n        = cnt - 24'd1;
        step_n       = step;
        index_n      = index;
        rs_n         = rs;
        e_n          = e;
        data_n       = data;
        init_done_n  = init_done;
        frame_done_n = 1'b0;

        case (state)
            ST_PWRUP: begin
                // cnt is 0 only in the first cycle after reset: that cycle
                // counts as the first of the power-up wait.
                if (cnt == 24'd1 || (cnt == 24'd0 && L_PWRUP == 24'd1)) begin
                    state_n = ST_INIT;
                    step_n  = 3'd0;
                    phase_n = PH_SETUP;
                    cnt_n   = L_SETUP;
                end else if (cnt == 24'd0) begin
                    cnt_n = L_PWRUP - 24'd1;
                end
            end

            ST_REFRESH: begin
                if (last) begin
                    state_n = ST_ADDR1;
                    phase_n = PH_SETUP;
                    cnt_n   = L_SETUP;
                end
            end

            default: begin
                case (phase)
                    PH_SETUP: begin
                        // Load at the end of the first SETUP cycle; index was
                        // moved at the start of the previous WAIT, so char_in
                        // already reflects it.
                        if (cnt == L_SETUP) begin
                            rs_n   = (state == ST_CHAR);
                            data_n = byte_sel;
                        end
                        if (last) begin
                            phase_n = PH_EHIGH;
                            cnt_n   = L_EHIGH;
                            e_n     = 1'b1;
                        end
                    end

                    PH_EHIGH: begin
                        if (last) begin
                            phase_n = PH_HOLD;
                            cnt_n   = L_HOLD;
                            e_n     = 1'b0;
                        end
                    end

                    PH_HOLD: begin
                        if (last) begin
                            phase_n = PH_WAIT;
                            cnt_n   = (!rs && data == 8'h01) ? L_CLR : L_CMD;
                            // Advance index/step now so the registered display
                            // list has the whole WAIT to catch up.
                            case (state)
                                ST_INIT: begin
                                    if (step == 3'd4) nxt_n = ST_ADDR1;
                                    else begin
                                        nxt_n  = ST_INIT;
                                        step_n = step + 3'd1;
                                    end
                                end
                                ST_ADDR1, ST_ADDR2: nxt_n = ST_CHAR;
                                default: begin
                                    if (index == 5'd31) begin
                                        index_n = 5'd0;
                                        nxt_n   = ST_REFRESH;
                                    end else begin
                                        index_n = index + 5'd1;
                                        nxt_n   = (index == 5'd15) ? ST_ADDR2 : ST_CHAR;
                                    end
                                end
                            endcase
                        end
                    end

                    default: begin
                        if (last) begin
                            state_n = nxt;
                            if (nxt == ST_REFRESH) begin
                                frame_done_n = 1'b1;
                                cnt_n        = L_REFRESH;
                            end else begin
                                phase_n = PH_SETUP;
                                cnt_n   = L_SETUP;
                                // Only the end of the init list reaches ADDR1 via WAIT.
                                if (nxt == ST_ADDR1) init_done_n = 1'b1;
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PWRUP;
            nxt        <= ST_INIT;
            phase      <= PH_SETUP;
            cnt        <= 24'd0;
            step       <= 3'd0;
            index      <= 5'd0;
            rs         <= 1'b0;
            e          <= 1'b0;
            data       <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            nxt        <= nxt_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            step       <= step_n;
            index      <= index_n;
            rs         <= rs_n;
            e          <= e_n;
            data       <= data_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
        end
    end

    assign bus.index      = index;
    assign bus.lcd_rs     = rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e;
    assign bus.lcd_data   = data;
    assign bus.init_done  = init_done;
    assign bus.frame_done = frame_done;

endmodule
